// File: rtl/collision_detector.sv
// Per-frame collision detector: ORs player/obstacle overlaps over a frame and latches them on the frame pulse.
// Optional overlap pixel counter is built only when COLLISION_PIXCOUNT_EN is defined.
module collision_detector #(
   parameter int N_OBJ = 8,
   parameter int CNTW  = 8,
   parameter int IDXW  = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
   input  logic             clk_pix,
   input  logic             rst_n,
   input  logic             frame,
   input  logic             de,
   input  logic             player_drawing,
   input  logic [N_OBJ-1:0] obj_drawing,
   input  logic [N_OBJ-1:0] obj_mask,
   input  logic             clear,
   output logic [N_OBJ-1:0] collision_vec,
   output logic             collision,
   output logic [IDXW-1:0]  first_idx,
   output logic             hit_pulse,
   output logic [N_OBJ-1:0] sticky_vec,
   output logic [CNTW-1:0]  hit_count,
   output logic [15:0]      overlap_pixels
);

   logic [N_OBJ-1:0] w_h;
   logic             w_h_any;
   logic             w_acc_any;
   logic [N_OBJ-1:0] r_acc;
   logic [N_OBJ-1:0] r_collision_vec;
   logic             r_collision;
   logic [IDXW-1:0]  r_first_idx;
   logic             r_hit_pulse;
   logic [N_OBJ-1:0] r_sticky_vec;
   logic [CNTW-1:0]  r_hit_count;

   // Lowest set bit wins; an empty vector encodes as 0.
   function automatic logic [IDXW-1:0] f_first_idx(input logic [N_OBJ-1:0] vec);
      logic [IDXW-1:0] idx;
      idx = '0;
      for (int i = N_OBJ - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = IDXW'(i);
         end
      end
      return idx;
   endfunction

   assign w_h       = obj_drawing & obj_mask & {N_OBJ{player_drawing & de}};
   assign w_h_any   = |w_h;
   assign w_acc_any = |r_acc;

   // Frame accumulator; the frame-cycle pixel seeds the next frame.
   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
      end else if (frame) begin
         r_acc <= w_h;
      end else begin
         r_acc <= r_acc | w_h;
      end
   end

   // Per-frame result registers, refreshed only at the frame latch.
   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         r_collision_vec <= '0;
         r_collision     <= 1'b0;
         r_first_idx     <= '0;
         r_hit_pulse     <= 1'b0;
      end else if (frame) begin
         r_collision_vec <= r_acc;
         r_collision     <= w_acc_any;
         r_first_idx     <= f_first_idx(r_acc);
         r_hit_pulse     <= w_acc_any;
      end else begin
         r_hit_pulse     <= 1'b0;
      end
   end

   // Sticky history and saturating hit-frame count; clear overrides the frame being latched.
   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky_vec <= '0;
         r_hit_count  <= '0;
      end else if (clear) begin
         r_sticky_vec <= '0;
         r_hit_count  <= '0;
      end else if (frame) begin
         r_sticky_vec <= r_sticky_vec | r_acc;
         if (w_acc_any && (r_hit_count != {CNTW{1'b1}})) begin
            r_hit_count <= r_hit_count + CNTW'(1);
         end else begin
            r_hit_count <= r_hit_count;
         end
      end else begin
         r_sticky_vec <= r_sticky_vec;
         r_hit_count  <= r_hit_count;
      end
   end

`ifdef COLLISION_PIXCOUNT_EN
   logic [15:0] r_pix_cnt;
   logic [15:0] r_overlap_pixels;

   // Overlap pixel counter, saturating at 16'hFFFF and reloaded with the frame-cycle pixel.
   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         r_pix_cnt        <= 16'd0;
         r_overlap_pixels <= 16'd0;
      end else if (frame) begin
         r_overlap_pixels <= r_pix_cnt;
         r_pix_cnt        <= {15'd0, w_h_any};
      end else if (w_h_any && (r_pix_cnt != 16'hFFFF)) begin
         r_pix_cnt        <= r_pix_cnt + 16'd1;
      end else begin
         r_pix_cnt        <= r_pix_cnt;
      end
   end

   assign overlap_pixels = r_overlap_pixels;
`else
   assign overlap_pixels = 16'd0;
`endif

   assign collision_vec = r_collision_vec;
   assign collision     = r_collision;
   assign first_idx     = r_first_idx;
   assign hit_pulse     = r_hit_pulse;
   assign sticky_vec    = r_sticky_vec;
   assign hit_count     = r_hit_count;

endmodule

// File: tb/tb_collision_detector.sv
// Directed scoreboard bench for collision_detector; a second instance with CNTW=2 covers counter saturation.
module tb_collision_detector;

   logic       clk_pix = 1'b0;
   logic       rst_n;
   logic       frame;
   logic       de;
   logic       player_drawing;
   logic [7:0] obj_drawing;
   logic [7:0] obj_mask;
   logic       clear;

   logic [7:0]  collision_vec;
   logic        collision;
   logic [2:0]  first_idx;
   logic        hit_pulse;
   logic [7:0]  sticky_vec;
   logic [7:0]  hit_count;
   logic [15:0] overlap_pixels;

   logic [7:0]  s_collision_vec;
   logic        s_collision;
   logic [2:0]  s_first_idx;
   logic        s_hit_pulse;
   logic [7:0]  s_sticky_vec;
   logic [1:0]  s_hit_count;
   logic [15:0] s_overlap_pixels;

   typedef struct {
      logic [7:0]  vec;
      logic [2:0]  idx;
      logic [7:0]  sticky;
      logic [7:0]  cnt;
      logic [1:0]  sat;
      logic [15:0] ov;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk_pix = ~clk_pix;

   collision_detector #(.N_OBJ(8), .CNTW(8)) u_dut (
      .clk_pix(clk_pix), .rst_n(rst_n), .frame(frame), .de(de),
      .player_drawing(player_drawing), .obj_drawing(obj_drawing), .obj_mask(obj_mask),
      .clear(clear), .collision_vec(collision_vec), .collision(collision),
      .first_idx(first_idx), .hit_pulse(hit_pulse), .sticky_vec(sticky_vec),
      .hit_count(hit_count), .overlap_pixels(overlap_pixels)
   );

   collision_detector #(.N_OBJ(8), .CNTW(2)) u_sat (
      .clk_pix(clk_pix), .rst_n(rst_n), .frame(frame), .de(de),
      .player_drawing(player_drawing), .obj_drawing(obj_drawing), .obj_mask(obj_mask),
      .clear(clear), .collision_vec(s_collision_vec), .collision(s_collision),
      .first_idx(s_first_idx), .hit_pulse(s_hit_pulse), .sticky_vec(s_sticky_vec),
      .hit_count(s_hit_count), .overlap_pixels(s_overlap_pixels)
   );

   function automatic logic [15:0] ov_exp(input int n);
`ifdef COLLISION_PIXCOUNT_EN
      return 16'(n);
`else
      return (n == 0) ? 16'd0 : 16'd0;
`endif
   endfunction

   function automatic exp_t mk(input logic [7:0] vec, input logic [2:0] idx, input logic [7:0] sticky,
                               input logic [7:0] cnt, input logic [1:0] sat, input int ov);
      exp_t e;
      e.vec = vec; e.idx = idx; e.sticky = sticky; e.cnt = cnt; e.sat = sat; e.ov = ov_exp(ov);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pixels(input logic [7:0] objs, input logic pl, input logic d, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_pix);
         obj_drawing = objs; player_drawing = pl; de = d;
      end
   endtask

   task automatic frame_step(input string tag, input logic [7:0] fobj, input logic fclr, input exp_t e);
      exp_t x;
      sb.push_back(e);
      @(negedge clk_pix);
      frame = 1'b1; clear = fclr; obj_drawing = fobj; player_drawing = (fobj != 8'h00); de = 1'b1;
      @(negedge clk_pix);
      frame = 1'b0; clear = 1'b0; obj_drawing = 8'h00; player_drawing = 1'b0;
      x = sb.pop_front();
      chk({tag, ".vec"},    32'(collision_vec),  32'(x.vec));
      chk({tag, ".coll"},   32'(collision),      32'(x.vec != 8'h00));
      chk({tag, ".idx"},    32'(first_idx),      32'(x.idx));
      chk({tag, ".pulse"},  32'(hit_pulse),      32'(x.vec != 8'h00));
      chk({tag, ".sticky"}, 32'(sticky_vec),     32'(x.sticky));
      chk({tag, ".cnt"},    32'(hit_count),      32'(x.cnt));
      chk({tag, ".sat"},    32'(s_hit_count),    32'(x.sat));
      chk({tag, ".ov"},     32'(overlap_pixels), 32'(x.ov));
      @(negedge clk_pix);
      chk({tag, ".pulse_drop"}, 32'(hit_pulse),     32'd0);
      chk({tag, ".hold"},       32'(collision_vec), 32'(x.vec));
   endtask

   task automatic all_zero(input string tag);
      chk({tag, ".vec"},    32'(collision_vec),  32'd0);
      chk({tag, ".coll"},   32'(collision),      32'd0);
      chk({tag, ".idx"},    32'(first_idx),      32'd0);
      chk({tag, ".pulse"},  32'(hit_pulse),      32'd0);
      chk({tag, ".sticky"}, 32'(sticky_vec),     32'd0);
      chk({tag, ".cnt"},    32'(hit_count),      32'd0);
      chk({tag, ".sat"},    32'(s_hit_count),    32'd0);
      chk({tag, ".ov"},     32'(overlap_pixels), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; frame = 1'b0; de = 1'b1; player_drawing = 1'b0;
      obj_drawing = 8'h00; obj_mask = 8'hFF; clear = 1'b0;
      #12;
      all_zero("reset");
      @(negedge clk_pix);
      rst_n = 1'b1;
      frame_step("sync", 8'h00, 1'b0, mk(8'h00, 3'd0, 8'h00, 8'd0, 2'd0, 0));

      // single hit on channel 3
      pixels(8'h08, 1'b1, 1'b1, 10);
      frame_step("single", 8'h00, 1'b0, mk(8'h08, 3'd3, 8'h08, 8'd1, 2'd1, 10));

      // clear without frame
      @(negedge clk_pix); clear = 1'b1;
      @(negedge clk_pix); clear = 1'b0;
      chk("clr.sticky", 32'(sticky_vec), 32'd0);
      chk("clr.cnt",    32'(hit_count),  32'd0);
      chk("clr.vec",    32'(collision_vec), 32'h08);

      // channels 2 and 5 with channel 5 masked
      obj_mask = 8'hDF;
      pixels(8'h24, 1'b1, 1'b1, 4);
      frame_step("mask", 8'h00, 1'b0, mk(8'h04, 3'd2, 8'h04, 8'd1, 2'd1, 4));
      obj_mask = 8'hFF;

      // overlap only on the frame cycle belongs to the next frame
      frame_step("bound_a", 8'h01, 1'b0, mk(8'h00, 3'd0, 8'h04, 8'd1, 2'd1, 0));
      frame_step("bound_b", 8'h00, 1'b0, mk(8'h01, 3'd0, 8'h05, 8'd2, 2'd2, 1));

      // clear together with frame
      pixels(8'h01, 1'b1, 1'b1, 2);
      frame_step("clr_frame", 8'h00, 1'b1, mk(8'h01, 3'd0, 8'h00, 8'd0, 2'd0, 2));

      // de low and player absent contribute nothing
      pixels(8'hFF, 1'b1, 1'b0, 3);
      pixels(8'hFF, 1'b0, 1'b1, 3);
      frame_step("nodraw", 8'h00, 1'b0, mk(8'h00, 3'd0, 8'h00, 8'd0, 2'd0, 0));

      // saturation of the 2-bit counter
      pixels(8'h02, 1'b1, 1'b1, 1);
      frame_step("sat1", 8'h00, 1'b0, mk(8'h02, 3'd1, 8'h02, 8'd1, 2'd1, 1));
      pixels(8'h02, 1'b1, 1'b1, 1);
      frame_step("sat2", 8'h00, 1'b0, mk(8'h02, 3'd1, 8'h02, 8'd2, 2'd2, 1));
      pixels(8'h02, 1'b1, 1'b1, 1);
      frame_step("sat3", 8'h00, 1'b0, mk(8'h02, 3'd1, 8'h02, 8'd3, 2'd3, 1));
      pixels(8'h02, 1'b1, 1'b1, 1);
      frame_step("sat4", 8'h00, 1'b0, mk(8'h02, 3'd1, 8'h02, 8'd4, 2'd3, 1));
      pixels(8'h02, 1'b1, 1'b1, 1);
      frame_step("sat5", 8'h00, 1'b0, mk(8'h02, 3'd1, 8'h02, 8'd5, 2'd3, 1));

      // asynchronous reset between clock edges, mid-frame
      pixels(8'h08, 1'b1, 1'b1, 2);
      @(posedge clk_pix);
      #2;
      rst_n = 1'b0; obj_drawing = 8'h00; player_drawing = 1'b0;
      #1;
      all_zero("async_rst");
      @(negedge clk_pix);
      rst_n = 1'b1;
      pixels(8'h10, 1'b1, 1'b1, 3);
      frame_step("post_rst", 8'h00, 1'b0, mk(8'h10, 3'd4, 8'h10, 8'd1, 2'd1, 3));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/collision_detector.md
COLLISION_DETECTOR -- requirements
Module: collision_detector

Interface
REQ-001 SHALL have parameter N_OBJ, default 8: number of obstacle channels checked against the player sprite (1..32).
REQ-002 SHALL have parameter CNTW, default 8: width of the saturating collision-frame counter.
REQ-003 SHALL have parameter IDXW, default $clog2(N_OBJ) (minimum 1): width of first_idx.
REQ-004 SHALL have port clk_pix  in  1: pixel clock; the block's only clock.
REQ-005 SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port frame  in  1: one-cycle start-of-frame pulse from the display timing generator.
REQ-007 SHALL have port de  in  1: data enable; high in the visible region.
REQ-008 SHALL have port player_drawing  in  1: the player sprite covers the current pixel.
REQ-009 SHALL have port obj_drawing  in  N_OBJ: bit i high when obstacle i covers the current pixel.
REQ-010 SHALL have port obj_mask  in  N_OBJ: bit i high enables checking of channel i.
REQ-011 SHALL have port clear  in  1: synchronous clear of sticky_vec and hit_count.
REQ-012 SHALL have port collision_vec  out  N_OBJ: per-channel hits from the last completed frame.
REQ-013 SHALL have port collision  out  1: OR-reduction of collision_vec.
REQ-014 SHALL have port first_idx  out  IDXW: lowest set index of collision_vec; 0 when none is set.
REQ-015 SHALL have port hit_pulse  out  1: one-cycle pulse when a completed frame contained any hit.
REQ-016 SHALL have port sticky_vec  out  N_OBJ: per-channel hits accumulated since the last clear.
REQ-017 SHALL have port hit_count  out  CNTW: number of frames containing a hit, saturating.
REQ-018 SHALL have port overlap_pixels  out  16: overlap pixel count of the last completed frame (see Configuration).

Function
REQ-019 SHALL form per-pixel hit vector h = obj_drawing & obj_mask & {N_OBJ{player_drawing & de}}.
REQ-020 SHALL OR h into the frame accumulator acc on every cycle where frame is low.
REQ-021 SHALL, on a cycle with frame high, latch collision_vec <= acc and load acc <= h. The pixel of the frame cycle belongs to the new frame and is not lost.
REQ-022 SHALL update collision_vec, collision, first_idx, hit_pulse, sticky_vec and hit_count on the clock edge that samples frame high, so they are visible one cycle after frame.
REQ-023 SHALL hold all outputs stable between frame pulses, except the effect of clear.
REQ-024 SHALL assert hit_pulse for exactly one cycle, and only when the latched acc is non-zero.
REQ-025 SHALL compute first_idx as a priority encoder of collision_vec, with the lowest index winning.
REQ-026 SHALL update sticky_vec <= sticky_vec | acc at each frame latch.
REQ-027 SHALL increment hit_count by 1 at each frame latch with non-zero acc, and hold at all-ones once saturated.
REQ-028 SHALL, when clear and frame are high in the same cycle, zero sticky_vec and hit_count, discard the latched frame's contribution to them, and still update collision_vec and hit_pulse normally.
REQ-029 SHALL apply obj_mask changes immediately; hits already accumulated in acc are not removed.
REQ-030 SHALL add no contribution to acc on cycles where de is low.

Reset
REQ-031 SHALL, while rst_n is low, force acc, collision_vec, collision, first_idx, hit_pulse, sticky_vec, hit_count and overlap_pixels to 0, without waiting for a clock edge.
REQ-032 SHALL, after a reset release mid-frame, accumulate only from the release point; the first frame pulse latches that partial frame.

Configuration
REQ-033 SHALL, with macro COLLISION_PIXCOUNT_EN defined, count cycles with a non-zero h in a 16-bit saturating counter. At each frame latch it copies the count to overlap_pixels and reloads the counter with (h != 0).
REQ-034 SHALL, without COLLISION_PIXCOUNT_EN, tie overlap_pixels to 0 and synthesize no counter logic.

Verification
REQ-035 SHALL test a single hit: N_OBJ=8, mask=FF, 10 overlap pixels on channel 3 in frame 1, then frame -> collision_vec=08, first_idx=3, hit_pulse=1 for one cycle, hit_count=1, overlap_pixels=10 (macro on).
REQ-036 SHALL test multiple channels and masking: hits on channels 2 and 5, mask=DF -> collision_vec=04, first_idx=2, sticky_vec=04.
REQ-037 SHALL test the frame-boundary pixel: overlap on channel 0 only in the cycle where frame=1 -> the next latch shows collision_vec=01, and the current latch excludes it.
REQ-038 SHALL test clear-versus-frame priority: clear and frame high together with acc=01 -> sticky_vec=0, hit_count=0, collision_vec=01, hit_pulse=1.
REQ-039 SHALL test saturation: CNTW=2, five consecutive hit frames -> hit_count sequence 1,2,3,3,3.
REQ-040 SHALL test async reset: rst_n low mid-frame between clock edges -> all outputs 0 immediately; an overlap after release is latched at the next frame pulse.
